// File: rtl/mips_pkg.sv
// Shared types and sizing for the MIPS memory stage.
package mips_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned RW              = 5;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [XLEN-1:0] aluresult;
        logic [XLEN-1:0] writedata;
        logic [RW-1:0]   writereg;
        logic            regwrite;
        logic            memtoreg;
        logic            memwrite;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0] readdata;
        logic [XLEN-1:0] aluresult;
        logic [RW-1:0]   writereg;
        logic            regwrite;
        logic            memtoreg;
        logic            memfault;
    } mem_wb_t;

    // Counter width able to hold TIMEOUT-1.
    function automatic int unsigned timeout_cw(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: request drive, wait counter, read buffer and fault flag.
module mem_access_fsm
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_memop,
    input  logic            i_misaligned,
    input  logic            i_stall_m,
    input  logic            i_ack,
    input  logic [XLEN-1:0] i_rdata,
    output logic            o_req_c,
    output logic            o_stall_c,
    output logic            o_fault_c,
    output logic            o_done_c,
    output logic [XLEN-1:0] o_rdata_c
);

    localparam int unsigned CW = timeout_cw(TIMEOUT);

    mem_state_t      r_state;
    mem_state_t      w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            r_fault;
    logic            w_fault_next;
    logic [XLEN-1:0] r_rbuf;
    logic [XLEN-1:0] w_rbuf_next;
    logic            w_timeout_hit;

    assign w_timeout_hit = (r_state == WAIT) && (r_cnt == CW'(TIMEOUT - 1));

    // State, wait counter, buffered load data and fault flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_rbuf  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_fault <= w_fault_next;
            r_rbuf  <= w_rbuf_next;
        end
    end

    // Next state, counter update, and combinational request/stall/fault drive.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_fault_next = r_fault;
        w_rbuf_next  = r_rbuf;
        o_req_c      = 1'b0;
        o_stall_c    = 1'b0;
        o_fault_c    = 1'b0;
        o_done_c     = 1'b0;
        o_rdata_c    = '0;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (i_memop && !i_misaligned) begin
                    o_req_c = 1'b1;
                    if (i_ack) begin
                        o_rdata_c = i_rdata;
                        if (i_stall_m) begin
                            w_state_next = DONE;
                            w_rbuf_next  = i_rdata;
                            w_fault_next = 1'b0;
                        end
                    end else begin
                        o_stall_c    = 1'b1;
                        w_state_next = WAIT;
                        // The IDLE request cycle counts as the first wait cycle.
                        w_cnt_next   = CW'(1);
                    end
                end else if (i_misaligned) begin
                    o_fault_c = 1'b1;
                end
            end
            WAIT: begin
                if (w_timeout_hit) begin
                    o_fault_c    = 1'b1;
                    w_fault_next = 1'b1;
                    w_state_next = i_stall_m ? DONE : IDLE;
                end else begin
                    o_req_c    = 1'b1;
                    w_cnt_next = r_cnt + CW'(1);
                    if (i_ack) begin
                        o_rdata_c    = i_rdata;
                        w_rbuf_next  = i_rdata;
                        w_fault_next = 1'b0;
                        w_state_next = i_stall_m ? DONE : IDLE;
                    end else begin
                        o_stall_c = 1'b1;
                    end
                end
            end
            DONE: begin
                // Access already finished; never re-issue, just replay the result.
                o_done_c  = 1'b1;
                o_rdata_c = r_rbuf;
                o_fault_c = r_fault;
                if (!i_stall_m) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// MIPS memory stage: EX/MEM and MEM/WB pipeline registers around the data-memory sequencer.
module stage_memory
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned AW      = 32
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   aluresult_E,
    input  logic [31:0]   writedata_E,
    input  logic [4:0]    writereg_E,
    input  logic          regwrite_E,
    input  logic          memtoreg_E,
    input  logic          memwrite_E,
    input  logic          stall_M,
    input  logic          flush_M,
    output logic [31:0]   aluresult_MEM,
    output logic [4:0]    writereg_M,
    output logic          regwrite_M,
    output logic          stall_mem,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    output logic [31:0]   readdata_W,
    output logic [31:0]   aluresult_W,
    output logic [4:0]    writereg_W,
    output logic          regwrite_W,
    output logic          memtoreg_W,
    output logic          memfault_W
);

    ex_mem_t         r_exmem;
    mem_wb_t         r_memwb;
    ex_mem_t         w_exmem_in;
    logic            w_memop;
    logic            w_misaligned;
    logic            w_adv;
    logic            w_wb_bubble;
    logic            w_req;
    logic            w_stall;
    logic            w_fault;
    logic            w_done;
    logic [XLEN-1:0] w_rdata;

    assign w_exmem_in = '{aluresult: aluresult_E, writedata: writedata_E,
                          writereg: writereg_E, regwrite: regwrite_E,
                          memtoreg: memtoreg_E, memwrite: memwrite_E};

    assign w_memop      = r_exmem.memtoreg | r_exmem.memwrite;
    assign w_misaligned = w_memop & (r_exmem.aluresult[1:0] != 2'b00);
    assign w_adv        = !stall_M && !w_stall;
    assign w_wb_bubble  = w_stall || stall_M || (w_done && !w_adv);

    mem_access_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk          (clk),
        .reset        (reset),
        .i_memop      (w_memop),
        .i_misaligned (w_misaligned),
        .i_stall_m    (stall_M),
        .i_ack        (dmem_ack),
        .i_rdata      (dmem_rdata),
        .o_req_c      (w_req),
        .o_stall_c    (w_stall),
        .o_fault_c    (w_fault),
        .o_done_c     (w_done),
        .o_rdata_c    (w_rdata)
    );

    // EX/MEM: advance on adv (bubble on flush); hold otherwise, flush included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exmem <= '0;
        end else if (w_adv) begin
            r_exmem <= flush_M ? '0 : w_exmem_in;
        end
    end

    // MEM/WB: bubble while the access or downstream is stalled; faults kill regwrite.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memwb <= '0;
        end else if (w_wb_bubble) begin
            r_memwb <= '0;
        end else begin
            r_memwb <= '{readdata: w_rdata, aluresult: r_exmem.aluresult,
                         writereg: r_exmem.writereg,
                         regwrite: r_exmem.regwrite & !w_fault,
                         memtoreg: r_exmem.memtoreg, memfault: w_fault};
        end
    end

    assign aluresult_MEM = r_exmem.aluresult;
    assign writereg_M    = r_exmem.writereg;
    assign regwrite_M    = r_exmem.regwrite;
    assign stall_mem     = w_stall;
    assign dmem_req      = w_req;
    assign dmem_we       = w_req & r_exmem.memwrite;
    assign dmem_addr     = {r_exmem.aluresult[AW-1:2], 2'b00};
    assign dmem_wdata    = r_exmem.writedata;

    assign readdata_W    = r_memwb.readdata;
    assign aluresult_W   = r_memwb.aluresult;
    assign writereg_W    = r_memwb.writereg;
    assign regwrite_W    = r_memwb.regwrite;
    assign memtoreg_W    = r_memwb.memtoreg;
    assign memfault_W    = r_memwb.memfault;

endmodule

// File: tb/tb_stage_memory.sv
// Scoreboard bench for the MIPS memory stage.
module tb_stage_memory;

    logic        clk;
    logic        reset;
    logic [31:0] aluresult_E;
    logic [31:0] writedata_E;
    logic [4:0]  writereg_E;
    logic        regwrite_E;
    logic        memtoreg_E;
    logic        memwrite_E;
    logic        stall_M;
    logic        flush_M;
    logic [31:0] aluresult_MEM;
    logic [4:0]  writereg_M;
    logic        regwrite_M;
    logic        stall_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] readdata_W;
    logic [31:0] aluresult_W;
    logic [4:0]  writereg_W;
    logic        regwrite_W;
    logic        memtoreg_W;
    logic        memfault_W;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        rw;
        logic        mt;
        logic        flt;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    stage_memory #(.TIMEOUT(16), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .aluresult_E(aluresult_E), .writedata_E(writedata_E), .writereg_E(writereg_E),
        .regwrite_E(regwrite_E), .memtoreg_E(memtoreg_E), .memwrite_E(memwrite_E),
        .stall_M(stall_M), .flush_M(flush_M),
        .aluresult_MEM(aluresult_MEM), .writereg_M(writereg_M), .regwrite_M(regwrite_M),
        .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .readdata_W(readdata_W), .aluresult_W(aluresult_W), .writereg_W(writereg_W),
        .regwrite_W(regwrite_W), .memtoreg_W(memtoreg_W), .memfault_W(memfault_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                         input logic rw, input logic mt, input logic mw);
        aluresult_E = alu; writedata_E = wd; writereg_E = wr;
        regwrite_E = rw; memtoreg_E = mt; memwrite_E = mw;
    endtask

    task automatic clear_e();
        set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        clear_e(); stall_M = 1'b0; flush_M = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic wb_valid();
        return (aluresult_W != 32'h0) || (readdata_W != 32'h0) || (writereg_W != 5'd0) ||
               regwrite_W || memtoreg_W || memfault_W;
    endfunction

    function automatic wb_t get_obs();
        return {readdata_W, aluresult_W, writereg_W, regwrite_W, memtoreg_W, memfault_W};
    endfunction

    function automatic logic [176:0] all_outs();
        return {aluresult_MEM, writereg_M, regwrite_M, stall_mem, dmem_req, dmem_we,
                dmem_addr, dmem_wdata, readdata_W, aluresult_W, writereg_W,
                regwrite_W, memtoreg_W, memfault_W};
    endfunction

    task automatic test_reset();
        reset = 1'b1; stall_M = 1'b0; flush_M = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        clear_e();
        #3;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        set_e(32'hFFFF_FFFF, 32'h1234_5678, 5'd31, 1'b1, 1'b1, 1'b0);
        dmem_ack = 1'b1;
        tick(); tick();
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL reset_hold: got %h expected 0", all_outs());
        end
        clear_e(); dmem_ack = 1'b0;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_alu_op();
        wb_t obs;
        wb_t e;
        int  n;
        set_e(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        exp_q.push_back('{rd: 32'h0, alu: 32'h1234, wr: 5'd5, rw: 1'b1, mt: 1'b0, flt: 1'b0});
        tick();
        clear_e(); #1;
        n_checks++;
        if ({aluresult_MEM, writereg_M, regwrite_M} !== {32'h1234, 5'd5, 1'b1}) begin
            n_fail++; $display("FAIL alu_exmem: got %h/%0d/%b expected 1234/5/1",
                               aluresult_MEM, writereg_M, regwrite_M);
        end
        n_checks++;
        if ({dmem_req, stall_mem} !== 2'b00) begin
            n_fail++; $display("FAIL alu_noreq: req=%b stall=%b expected 0/0", dmem_req, stall_mem);
        end
        n = 1;
        while (!wb_valid() && n < 10) begin tick(); n++; end
        n_checks++;
        if (!wb_valid() || n != 2) begin
            n_fail++; $display("FAIL alu_latency: got %0d cycles expected 2", n);
        end else begin
            e = exp_q.pop_front(); obs = get_obs();
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL alu_wb: got %h expected %h", obs, e);
            end
        end
        idle(2);
    endtask

    task automatic test_load_zero_wait();
        wb_t obs;
        wb_t e;
        set_e(32'h40, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
        exp_q.push_back('{rd: 32'hDEAD_BEEF, alu: 32'h40, wr: 5'd7, rw: 1'b1, mt: 1'b1, flt: 1'b0});
        tick();
        clear_e(); dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
        n_checks++;
        if ({dmem_req, dmem_we, stall_mem, dmem_addr} !== {1'b1, 1'b0, 1'b0, 32'h40}) begin
            n_fail++; $display("FAIL load0_req: req=%b we=%b stall=%b addr=%h expected 1/0/0/40",
                               dmem_req, dmem_we, stall_mem, dmem_addr);
        end
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        n_checks++;
        if (!wb_valid()) begin
            n_fail++; $display("FAIL load0_latency: W still bubble after 2 cycles");
        end else begin
            e = exp_q.pop_front(); obs = get_obs();
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL load0_wb: got %h expected %h", obs, e);
            end
        end
        idle(2);
    endtask

    task automatic test_store_wait();
        wb_t obs;
        wb_t e;
        int  stalls;
        stalls = 0;
        set_e(32'h80, 32'hCAFE_F00D, 5'd3, 1'b0, 1'b0, 1'b1);
        exp_q.push_back('{rd: 32'h0, alu: 32'h80, wr: 5'd3, rw: 1'b0, mt: 1'b0, flt: 1'b0});
        tick();
        clear_e();
        for (int c = 0; c < 4; c++) begin
            dmem_ack = (c == 3); #1;
            if (stall_mem) stalls++;
            n_checks++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h80, 32'hCAFE_F00D}) begin
                n_fail++; $display("FAIL store_bus c%0d: req=%b we=%b addr=%h wdata=%h", c,
                                   dmem_req, dmem_we, dmem_addr, dmem_wdata);
            end
            n_checks++;
            if (wb_valid()) begin
                n_fail++; $display("FAIL store_wb_bubble c%0d: got %h expected bubble", c, get_obs());
            end
            tick();
            dmem_ack = 1'b0;
        end
        n_checks++;
        if (stalls != 3) begin
            n_fail++; $display("FAIL store_stall_cycles: got %0d expected 3", stalls);
        end
        n_checks++;
        if (!wb_valid()) begin
            n_fail++; $display("FAIL store_latency: W bubble after 5 cycles");
        end else begin
            e = exp_q.pop_front(); obs = get_obs();
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL store_wb: got %h expected %h", obs, e);
            end
        end
        idle(2);
    endtask

    task automatic test_misaligned();
        wb_t obs;
        wb_t e;
        set_e(32'h42, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
        exp_q.push_back('{rd: 32'h0, alu: 32'h42, wr: 5'd9, rw: 1'b0, mt: 1'b1, flt: 1'b1});
        tick();
        clear_e(); #1;
        n_checks++;
        if ({dmem_req, stall_mem} !== 2'b00) begin
            n_fail++; $display("FAIL misal_noreq: req=%b stall=%b expected 0/0", dmem_req, stall_mem);
        end
        tick();
        n_checks++;
        if (!wb_valid()) begin
            n_fail++; $display("FAIL misal_latency: W bubble after 2 cycles");
        end else begin
            e = exp_q.pop_front(); obs = get_obs();
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL misal_wb: got %h expected %h", obs, e);
            end
        end
        idle(2);
    endtask

    task automatic test_timeout();
        wb_t obs;
        wb_t e;
        int  stalls;
        int  reqs;
        stalls = 0; reqs = 0;
        set_e(32'h100, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        exp_q.push_back('{rd: 32'h0, alu: 32'h100, wr: 5'd4, rw: 1'b0, mt: 1'b1, flt: 1'b1});
        tick();
        clear_e();
        for (int c = 0; c < 16; c++) begin
            #1;
            if (stall_mem) stalls++;
            if (dmem_req) reqs++;
            if (c == 15) begin
                n_checks++;
                if ({dmem_req, stall_mem} !== 2'b00) begin
                    n_fail++; $display("FAIL timeout_drop: req=%b stall=%b expected 0/0",
                                       dmem_req, stall_mem);
                end
            end
            tick();
        end
        n_checks++;
        if (stalls != 15 || reqs != 15) begin
            n_fail++; $display("FAIL timeout_cycles: stall=%0d req=%0d expected 15/15", stalls, reqs);
        end
        n_checks++;
        if (!wb_valid()) begin
            n_fail++; $display("FAIL timeout_latency: W bubble after timeout");
        end else begin
            e = exp_q.pop_front(); obs = get_obs();
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL timeout_wb: got %h expected %h", obs, e);
            end
        end
        #1;
        n_checks++;
        if (dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after_req: got %b expected 0", dmem_req);
        end
        idle(2);
    endtask

    task automatic test_stall_store();
        wb_t obs;
        wb_t e;
        int  reqs;
        reqs = 0;
        set_e(32'h200, 32'h55AA_00FF, 5'd0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back('{rd: 32'h0, alu: 32'h200, wr: 5'd0, rw: 1'b0, mt: 1'b0, flt: 1'b0});
        tick();
        clear_e(); dmem_ack = 1'b1; dmem_rdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            stall_M = (c < 4); #1;
            if (dmem_req) reqs++;
            n_checks++;
            if (stall_mem !== 1'b0 || wb_valid()) begin
                n_fail++; $display("FAIL stst_c%0d: stall_mem=%b wb=%h expected 0/bubble",
                                   c, stall_mem, get_obs());
            end
            tick();
        end
        stall_M = 1'b0;
        n_checks++;
        if (!wb_valid()) begin
            n_fail++; $display("FAIL stst_latency: W bubble after stall released");
        end else begin
            e = exp_q.pop_front(); obs = get_obs();
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL stst_wb: got %h expected %h", obs, e);
            end
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            if (dmem_req) reqs++;
            tick();
        end
        n_checks++;
        if (reqs != 1) begin
            n_fail++; $display("FAIL stst_one_txn: got %0d requests expected 1", reqs);
        end
        idle(2);
    endtask

    task automatic test_stall_load_buffer();
        wb_t obs;
        wb_t e;
        set_e(32'h300, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0);
        exp_q.push_back('{rd: 32'h1357_2468, alu: 32'h300, wr: 5'd11, rw: 1'b1, mt: 1'b1, flt: 1'b0});
        tick();
        clear_e(); stall_M = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1357_2468;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_0000;
        tick();
        stall_M = 1'b0;
        n_checks++;
        if (wb_valid()) begin
            n_fail++; $display("FAIL stld_bubble: got %h expected bubble", get_obs());
        end
        tick();
        n_checks++;
        if (!wb_valid()) begin
            n_fail++; $display("FAIL stld_latency: W bubble after stall released");
        end else begin
            e = exp_q.pop_front(); obs = get_obs();
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL stld_wb: got %h expected %h", obs, e);
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        wb_t obs;
        wb_t e;
        for (int t = 0; t < 9; t++) begin
            if (t < 5) begin
                set_e(32'h1000 + 32'(t * 4), 32'h0, 5'(t + 1), 1'b1, 1'b0, 1'b0);
                flush_M = (t == 2);
                if (t != 2)
                    exp_q.push_back('{rd: 32'h0, alu: 32'h1000 + 32'(t * 4), wr: 5'(t + 1),
                                      rw: 1'b1, mt: 1'b0, flt: 1'b0});
            end else begin
                clear_e(); flush_M = 1'b0;
            end
            tick();
            if (wb_valid()) begin
                obs = get_obs();
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got %h expected bubble", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_fail++; $display("FAIL b2b_wb t%0d: got %h expected %h", t, obs, e);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_missing: %0d entries never reached W expected 0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    task automatic test_reset_mid_wait();
        set_e(32'h400, 32'h77, 5'd2, 1'b0, 1'b0, 1'b1);
        tick();
        clear_e(); dmem_ack = 1'b0; #1;
        n_checks++;
        if ({dmem_req, stall_mem} !== 2'b11) begin
            n_fail++; $display("FAIL rst_wait_pre: req=%b stall=%b expected 1/1", dmem_req, stall_mem);
        end
        tick();
        n_checks++;
        if (dmem_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait_req: got %b expected 1", dmem_req);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL rst_wait_outs: got %h expected 0", all_outs());
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({dmem_req, stall_mem} !== 2'b00) begin
            n_fail++; $display("FAIL rst_wait_after: req=%b stall=%b expected 0/0", dmem_req, stall_mem);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_zero_wait();
        test_store_wait();
        test_misaligned();
        test_timeout();
        test_stall_store();
        test_stall_load_buffer();
        test_back_to_back();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and runs load/store word accesses to the data memory over a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Drives the MEM/WB register that feeds writeback, and provides aluresult_MEM to the execute-stage bypass muxes.

Parameters:
- TIMEOUT, 16: cycles to wait for dmem_ack before declaring a bus fault; must be ≥ 2.
- AW, 32: data memory address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- aluresult_E  in  32  ALU result / effective address from execute
- writedata_E  in  32  store data, already forwarded
- writereg_E  in  5  destination register
- regwrite_E  in  1  register write enable
- memtoreg_E  in  1  instruction is a load
- memwrite_E  in  1  instruction is a store
- stall_M  in  1  hold request from hazard unit
- flush_M  in  1  insert bubble into EX/MEM
- aluresult_MEM  out  32  EX/MEM aluresult, used for bypass
- writereg_M  out  5  EX/MEM destination, used by hazard unit
- regwrite_M  out  1  EX/MEM regwrite, used by hazard unit
- stall_mem  out  1  access in progress; freeze IF..EX
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  AW  word address, {aluresult[AW-1:2],2'b00}
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete; rdata valid on loads
- dmem_rdata  in  32  load data
- readdata_W  out  32  MEM/WB load data
- aluresult_W  out  32  MEM/WB ALU result
- writereg_W  out  5  MEM/WB destination
- regwrite_W  out  1  MEM/WB write enable
- memtoreg_W  out  1  MEM/WB select load data
- memfault_W  out  1  misaligned access or timeout reached writeback

Behaviour:
- Reset (async): all EX/MEM and MEM/WB fields are 0 (bubble), FSM is IDLE, timeout counter is 0. Consequently dmem_req=0, stall_mem=0 and every output is 0.
- Definitions:
  - memop = memtoreg_M | memwrite_M.
  - misaligned = memop & (aluresult_M[1:0] != 0).
  - adv = !stall_M & !stall_mem.
- EX/MEM register:
  - Loads the E inputs when adv.
  - flush_M with adv loads a bubble (all control bits 0).
  - Otherwise it holds. flush_M is ignored while stall_mem=1, because the access must finish.
- FSM states: IDLE, WAIT, DONE.
  - IDLE:
    - If memop & !misaligned, dmem_req=1 combinationally and the counter clears.
    - If dmem_ack arrives in the same cycle, the access completes with zero wait and no stall. The FSM goes to DONE if stall_M=1, else stays IDLE.
    - Without ack, the FSM goes to WAIT.
  - WAIT:
    - dmem_req=1, with address, data and we held stable. Counter increments each cycle.
    - On ack: go to DONE if stall_M, else IDLE.
    - On counter reaching TIMEOUT-1 with no ack: set the fault bit, drop req, go to DONE if stall_M, else IDLE.
  - DONE:
    - No request; load data is held in an internal buffer.
    - Leave to IDLE when stall_M falls and the EX/MEM register advances.
    - Never re-issue the same access, so a store is never written twice.
- stall_mem = (IDLE & memop & !misaligned & !dmem_ack) | (WAIT & !dmem_ack & !timeout_hit).
- Misaligned access: no request is issued, there is no stall, the fault bit is set, and regwrite is suppressed.
- MEM/WB register:
  - When stall_mem=1, stall_M=1, or the FSM is still in DONE, it loads a bubble.
  - Otherwise it loads readdata (ack data, or the DONE buffer), aluresult_M, writereg_M, and memtoreg_M.
  - regwrite_W = regwrite_M & !fault.
  - memfault_W = fault.
- Latency:
  - ALU op: E to W in 2 cycles.
  - Load with N wait cycles: 2+N cycles.
- reset during WAIT drops dmem_req immediately; the memory must discard the request.

Decomposition:
- mips_pkg holds:
  - the mem_state_t enum {IDLE, WAIT, DONE};
  - the ex_mem_t and mem_wb_t packed structs;
  - the TIMEOUT counter width, $clog2(TIMEOUT).
- One sub-module, mem_access_fsm, contains the FSM, counter, request drive, read buffer and fault flag. The pipeline registers stay in stage_memory.

Test Plan:
- ALU op, aluresult_E=0x1234, writereg_E=5, regwrite_E=1 -> two cycles later aluresult_W=0x1234, writereg_W=5, regwrite_W=1, memtoreg_W=0; dmem_req stays 0.
- Load at addr 0x40, ack in the same cycle with rdata=0xDEADBEEF -> no stall_mem; next cycle readdata_W=0xDEADBEEF, memtoreg_W=1, dmem_addr=0x40.
- Store at 0x80, wdata=0xCAFEF00D, ack after 3 cycles -> stall_mem=1 for exactly 3 cycles, dmem_we=1 and data stable throughout, W gets bubbles and then regwrite_W=0.
- Load at 0x42 -> dmem_req never asserted, memfault_W=1, regwrite_W=0, no stall.
- Load with no ack, TIMEOUT=16 -> stall_mem for 15 cycles, then memfault_W=1 and req drops.
- Store acked while stall_M=1 held 4 cycles -> exactly one dmem_req/ack transaction (no re-issue); reset asserted mid-WAIT -> dmem_req and all outputs 0 in the same cycle.
